srio_swrite_unpack_mc: RTL and testbench
========================================

SRIO_SWRITE_UNPACK_MC -- requirements
Module: srio_swrite_unpack_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 64: stream width in bits; legal values are 64 and 128.
REQ-002 Parameter NUM_CH, default 4: number of address/channel slots; legal range is 1..8.
REQ-003 Parameter TDEST_WIDTH, default 4: output TDEST width; must satisfy 2^TDEST_WIDTH > NUM_CH.
REQ-004 AXIS_ACLK  in  1  is the single clock; all logic is on its rising edge.
REQ-005 AXIS_ARESET  in  1  is the reset: asynchronous, active-high.
REQ-006 S_AXIS_TVALID/TREADY/TLAST  in/out/in  1 each: SWRITE packet input handshake.
REQ-007 S_AXIS_TDATA  in  DATA_WIDTH  is the input data; beat 0 is the SRIO HELLO header, whose address is TDATA[31:0].
REQ-008 M_AXIS_TVALID/TREADY/TLAST  out/in/out  1 each: payload output handshake.
REQ-009 M_AXIS_TDATA  out  DATA_WIDTH  carries the payload only; the header is removed.
REQ-010 M_AXIS_TDEST  out  TDEST_WIDTH  is the index of the matched channel.
REQ-011 M_AXIS_TID  out  1  equals M_AXIS_TDEST[0].
REQ-012 cmd  in  32  is the control word: bit0 is start, bit1 is abort (level-sensitive).
REQ-013 addr_table  in  32*NUM_CH  holds the channel addresses; slot k occupies bits [32k+31:32k].
REQ-014 ch_enable  in  NUM_CH  enables matching per slot; a disabled slot never matches.
REQ-015 drop_cnt  out  32  counts dropped packets (see Configuration).

Function
REQ-016 A one-entry input register shall decouple S from M, giving 1 beat/cycle sustained throughput with no combinational path from M_AXIS_TREADY to S_AXIS_TREADY other than through the register's drain.
REQ-017 A beat accepted on S at cycle N shall be presentable on M at cycle N+1 at the earliest.
REQ-018 The master FSM states are IDLE, HDR, PAYLOAD, DROP and RESYNC.
REQ-019 IDLE: the input is stalled (TREADY=0 once the register is full) and M_AXIS_TVALID=0; start=1 moves to HDR, or to RESYNC if the mid-packet flag is set.
REQ-020 HDR: the header beat is consumed with no output; the address is compared against all enabled slots in parallel.
REQ-021 HDR with a match: the lowest matching index is latched into TDEST and the FSM moves to PAYLOAD.
REQ-022 HDR with no match: the FSM moves to DROP and drop_cnt increments.
REQ-023 A header beat carrying TLAST (runt packet) is discarded with no output, increments drop_cnt, and the FSM stays in HDR.
REQ-024 PAYLOAD: beats are forwarded with TDEST held constant; a transferred TLAST beat returns the FSM to HDR.
REQ-025 DROP: beats are consumed at 1/cycle with no output; a consumed TLAST beat returns the FSM to HDR.
REQ-026 RESYNC: beats are consumed and discarded up to and including the next TLAST, then the FSM moves to HDR; drop_cnt does not increment.
REQ-027 The mid-packet flag is set when a non-TLAST beat is consumed and cleared when a TLAST beat is consumed.
REQ-028 abort=1 forces IDLE from any state on the next edge and takes priority over start; the beat in flight on M is withdrawn.
REQ-029 M_AXIS_TVALID, once asserted, shall hold with stable TDATA, TLAST and TDEST until the beat transfers, except on abort.
REQ-030 addr_table and ch_enable are sampled only in HDR; changes mid-packet do not affect the current packet.
REQ-031 drop_cnt saturates at 0xFFFFFFFF.

Reset
REQ-032 AXIS_ARESET=1 shall asynchronously force: FSM=IDLE, input register empty, mid-packet flag=0, TDEST=0, drop_cnt=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0.
REQ-033 After reset deasserts, S_AXIS_TREADY=1 until the input register fills.

Configuration
REQ-034 When SRIO_UNPACK_DROP_CNT_EN is defined, drop_cnt counts as specified in REQ-022, REQ-023 and REQ-031.
REQ-035 When SRIO_UNPACK_DROP_CNT_EN is undefined, drop_cnt is tied to 0, no counter logic is synthesised, and all other behaviour is identical.

Verification
REQ-036 addr_table={0x30,0x20,0x10,0x00} with all slots enabled, start, then a 4-beat packet addressed to 0x20 -> 3 payload beats out with TDEST=2, TLAST on beat 3, and no bubbles when TREADY=1.
REQ-037 A packet to 0x99, a runt header to 0x10, then a packet to 0x00 -> drop_cnt=2 and only the 0x00 payload is output, with TDEST=0.
REQ-038 Slots 1 and 3 both set to 0x40 -> TDEST=1; with ch_enable[1]=0 -> TDEST=3.
REQ-039 Random M_AXIS_TREADY backpressure over 1000 packets -> payload is bit-exact, in order, and TVALID/TDATA stay stable while stalled.
REQ-040 Abort asserted on beat 2 of an 8-beat packet, then start -> the remaining beats are discarded (RESYNC), the next packet's header is parsed correctly, and drop_cnt is unchanged.
REQ-041 AXIS_ARESET asserted mid-PAYLOAD -> all outputs are at their reset values within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/srio_swrite_unpack_mc_if.sv
// AXI4-Stream bundle shared by the SWRITE unpacker input and output.
// The master modport drives the payload fields; the slave modport drives TREADY.
interface srio_swrite_unpack_mc_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TDEST_WIDTH = 4
);
  logic                   TVALID;
  logic                   TREADY;
  logic                   TLAST;
  logic [DATA_WIDTH-1:0]  TDATA;
  logic [TDEST_WIDTH-1:0] TDEST;
  logic                   TID;

  modport master (output TVALID, TLAST, TDATA, TDEST, TID, input TREADY);
  modport slave  (input TVALID, TLAST, TDATA, TDEST, TID, output TREADY);
endinterface

// File: rtl/srio_swrite_unpack_mc.sv
// SRIO SWRITE unpacker: strips the header beat and routes the payload to the matching channel.
// Optional saturating drop counter enabled by defining SRIO_UNPACK_DROP_CNT_EN.
module srio_swrite_unpack_mc #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TDEST_WIDTH = 4
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESET,
  srio_swrite_unpack_mc_if.slave  S_AXIS,
  srio_swrite_unpack_mc_if.master M_AXIS,
  input  logic [31:0]             cmd,
  input  logic [32*NUM_CH-1:0]    addr_table,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [31:0]             drop_cnt
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned TW = TDEST_WIDTH;
  localparam int unsigned AW = 32;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DROP, RESYNC} state_e;

  state_e          state_q, state_d;
  logic            full_q, full_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic            mid_q, mid_d;
  logic [TW-1:0]   tdest_q, tdest_d;
  logic            m_valid_q, m_valid_d;
  logic            rdy_en_q;
  logic            drain;
  logic            accept;
  logic            drop_inc;
  logic            s_ready_c;
  logic            start;
  logic            abort;
  logic            hit;
  logic [TW-1:0]   hit_idx;
  logic            unused_ok;

  assign start = cmd[0];
  assign abort = cmd[1];

  // Parallel address compare; iterating downwards leaves the lowest matching slot.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (ch_enable[k] && (addr_table[AW*k +: AW] == data_q[AW-1:0])) begin
        hit     = 1'b1;
        hit_idx = TW'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mid_d    = mid_q;
    tdest_d  = tdest_q;
    drain    = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = mid_q ? RESYNC : HDR;
      HDR: begin
        if (full_q) begin
          drain = 1'b1;
          if (last_q) begin
            drop_inc = 1'b1;
          end else if (hit) begin
            tdest_d = hit_idx;
            state_d = PAYLOAD;
          end else begin
            drop_inc = 1'b1;
            state_d  = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (m_valid_q && M_AXIS.TREADY) begin
          drain = 1'b1;
          if (last_q) state_d = HDR;
        end
      end
      DROP, RESYNC: begin
        if (full_q) begin
          drain = 1'b1;
          if (last_q) state_d = HDR;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drain) mid_d = ~last_q;
    // Abort freezes consumption and withdraws any presented beat.
    if (abort) begin
      state_d  = IDLE;
      drain    = 1'b0;
      drop_inc = 1'b0;
      mid_d    = mid_q;
      tdest_d  = tdest_q;
    end
  end

  assign s_ready_c = rdy_en_q && (!full_q || drain);
  assign accept    = S_AXIS.TVALID && s_ready_c;
  assign full_d    = accept ? 1'b1 : (drain ? 1'b0 : full_q);
  assign data_d    = accept ? S_AXIS.TDATA : data_q;
  assign last_d    = accept ? S_AXIS.TLAST : last_q;
  assign m_valid_d = (state_d == PAYLOAD) && full_d;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q   <= IDLE;
      full_q    <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      mid_q     <= 1'b0;
      tdest_q   <= '0;
      m_valid_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      data_q    <= data_d;
      last_q    <= last_d;
      mid_q     <= mid_d;
      tdest_q   <= tdest_d;
      m_valid_q <= m_valid_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign S_AXIS.TREADY = s_ready_c;
  assign M_AXIS.TVALID = m_valid_q;
  assign M_AXIS.TDATA  = data_q;
  assign M_AXIS.TLAST  = last_q;
  assign M_AXIS.TDEST  = tdest_q;
  assign M_AXIS.TID    = tdest_q[0];

`ifdef SRIO_UNPACK_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign unused_ok = ^{cmd[31:2], S_AXIS.TDEST, S_AXIS.TID, drop_inc};

endmodule

// File: tb/tb_srio_swrite_unpack_mc.sv
// Directed and randomised bench for srio_swrite_unpack_mc with a payload scoreboard.
module tb_srio_swrite_unpack_mc;

  localparam int unsigned DW  = 64;
  localparam int unsigned NCH = 4;
  localparam int unsigned TW  = 4;
  localparam int          LIM = 2000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] dest;
    logic          tid;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0]       cmd;
  logic [32*NCH-1:0] addr_table;
  logic [NCH-1:0]    ch_enable;
  logic [31:0]       drop_cnt;

  srio_swrite_unpack_mc_if #(.DATA_WIDTH(DW), .TDEST_WIDTH(TW)) s_if ();
  srio_swrite_unpack_mc_if #(.DATA_WIDTH(DW), .TDEST_WIDTH(TW)) m_if ();

  srio_swrite_unpack_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .TDEST_WIDTH(TW)) dut (
    .AXIS_ACLK  (clk),
    .AXIS_ARESET(rst),
    .S_AXIS     (s_if.slave),
    .M_AXIS     (m_if.master),
    .cmd        (cmd),
    .addr_table (addr_table),
    .ch_enable  (ch_enable),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    xfers = 0;
  int    first_x = 0;
  int    last_x = 0;
  int    exp_drops = 0;
  int    rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-side ready: 0 = always ready, 1 = random backpressure, 2 = stalled.
  initial begin
    m_if.TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.TREADY = 1'b1;
        1:       m_if.TREADY = 1'($urandom_range(0, 1));
        default: m_if.TREADY = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on transfer, hold-stability check while stalled.
  initial begin
    beat_t cur, prev, e;
    logic  prev_stall, prev_abort;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.data = m_if.TDATA;
      cur.last = m_if.TLAST;
      cur.dest = m_if.TDEST;
      cur.tid  = m_if.TID;
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !prev_abort) begin
          total++;
          assert (m_if.TVALID === 1'b1 && cur === prev) else begin
            bad++;
            $error("FAIL stall_hold observed valid=%0b beat=%0h expected valid=1 beat=%0h",
                   m_if.TVALID, cur, prev);
          end
        end
        if (m_if.TVALID === 1'b1 && m_if.TREADY === 1'b1) begin
          total++;
          assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL extra_beat observed beat=%0h expected none", cur);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (cur === e) else begin
              bad++;
              $error("FAIL payload observed=%0h expected=%0h", cur, e);
            end
          end
          xfers++;
          if (xfers == 1) first_x = cyc;
          last_x = cyc;
        end
        prev_stall = (m_if.TVALID === 1'b1) && (m_if.TREADY !== 1'b1);
        prev_abort = cmd[1];
        prev       = cur;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_drops(input string tag);
    logic [31:0] e;
`ifdef SRIO_UNPACK_DROP_CNT_EN
    e = 32'(exp_drops);
`else
    e = '0;
`endif
    chk(tag, 64'(drop_cnt), 64'(e));
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int w;
    w = 0;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = d;
    s_if.TLAST  = l;
    @(negedge clk);
    while (s_if.TREADY !== 1'b1 && w < LIM) begin
      @(negedge clk);
      w++;
    end
    total++;
    assert (w < LIM) else begin
      bad++;
      $error("FAIL s_handshake observed wait=%0d expected below %0d", w, LIM);
    end
    @(posedge clk);
    #1;
    s_if.TVALID = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  // dest < 0 means the packet must be dropped; npay == 0 is a runt header.
  task automatic send_pkt(input logic [31:0] addr, input int npay, input int dest);
    logic [DW-1:0] d;
    beat_t         e;
    d = rnd_data();
    d[31:0] = addr;
    if (npay == 0 || dest < 0) exp_drops++;
    send_beat(d, npay == 0);
    for (int i = 1; i <= npay; i++) begin
      d = rnd_data();
      if (dest >= 0) begin
        e.data = d;
        e.last = (i == npay);
        e.dest = TW'(dest);
        e.tid  = e.dest[0];
        exp_q.push_back(e);
      end
      send_beat(d, i == npay);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    total++;
    assert (w < 20000) else begin
      bad++;
      $error("FAIL drain observed pending=%0d expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic int model_dest(input logic [31:0] a);
    for (int k = 0; k < int'(NCH); k++) begin
      if (ch_enable[k] && addr_table[32*k +: 32] == a) return k;
    end
    return -1;
  endfunction

  initial begin
    logic [DW-1:0] hdr, p1;
    logic [31:0]   pick;
    rst = 1'b1;
    cmd = '0;
    addr_table = '0;
    ch_enable = '0;
    s_if.TVALID = 1'b0;
    s_if.TDATA = '0;
    s_if.TLAST = 1'b0;
    s_if.TDEST = '0;
    s_if.TID = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_if.TREADY), 64'd0);
    chk("rst_m_tvalid", 64'(m_if.TVALID), 64'd0);
    chk("rst_m_tlast",  64'(m_if.TLAST),  64'd0);
    chk("rst_m_tdata",  64'(m_if.TDATA),  64'd0);
    chk("rst_m_tdest",  64'(m_if.TDEST),  64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt),    64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_if.TREADY), 64'd1);

    // Basic routing, no bubbles
    addr_table = {32'h30, 32'h20, 32'h10, 32'h00};
    ch_enable = '1;
    cmd = 32'd1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    xfers = 0;
    send_pkt(32'h20, 3, 2);
    wait_drain();
    chk("basic_xfers", 64'(xfers), 64'd3);
    chk("basic_no_bubble", 64'(last_x - first_x), 64'd2);

    // Miss, runt, then a hit on slot 0
    xfers = 0;
    send_pkt(32'h99, 3, -1);
    send_pkt(32'h10, 0, -1);
    send_pkt(32'h00, 2, 0);
    wait_drain();
    chk("drop_xfers", 64'(xfers), 64'd2);
    check_drops("drop_cnt_two");

    // Duplicate addresses: lowest enabled slot wins
    addr_table = {32'h40, 32'h20, 32'h40, 32'h00};
    send_pkt(32'h40, 2, 1);
    wait_drain();
    ch_enable = 4'b1101;
    send_pkt(32'h40, 2, 3);
    wait_drain();

    // Abort on beat 2 of an 8-beat packet, then restart
    rdy_mode = 2;
    @(posedge clk);
    #1;
    hdr = rnd_data();
    hdr[31:0] = 32'h20;
    p1 = rnd_data();
    send_beat(hdr, 1'b0);
    send_beat(p1, 1'b0);
    @(negedge clk);
    chk("abort_pre_valid", 64'(m_if.TVALID), 64'd1);
    chk("abort_pre_data", 64'(m_if.TDATA), 64'(p1));
    @(posedge clk);
    #1;
    cmd = 32'd3;
    @(posedge clk);
    #1;
    cmd = 32'd0;
    @(negedge clk);
    chk("abort_withdraw", 64'(m_if.TVALID), 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_idle_valid", 64'(m_if.TVALID), 64'd0);
    @(posedge clk);
    #1;
    cmd = 32'd1;
    rdy_mode = 0;
    for (int i = 2; i <= 7; i++) send_beat(rnd_data(), i == 7);
    send_pkt(32'h00, 3, 0);
    wait_drain();
    check_drops("abort_drop_cnt");

    // Random backpressure over 1000 packets
    addr_table = {32'h30, 32'h20, 32'h10, 32'h00};
    ch_enable = '1;
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 4))
        0:       pick = 32'h00;
        1:       pick = 32'h10;
        2:       pick = 32'h20;
        3:       pick = 32'h30;
        default: pick = 32'h77;
      endcase
      send_pkt(pick, int'($urandom_range(0, 5)), model_dest(pick));
    end
    wait_drain();
    check_drops("random_drop_cnt");

    // Asynchronous reset in the middle of a payload
    rdy_mode = 2;
    @(posedge clk);
    #1;
    hdr = rnd_data();
    hdr[31:0] = 32'h10;
    p1 = rnd_data() | 64'h1;
    send_beat(hdr, 1'b0);
    send_beat(p1, 1'b0);
    @(negedge clk);
    chk("mid_pkt_valid", 64'(m_if.TVALID), 64'd1);
    chk("mid_pkt_dest", 64'(m_if.TDEST), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_tvalid", 64'(m_if.TVALID), 64'd0);
    chk("arst_m_tdata",  64'(m_if.TDATA),  64'd0);
    chk("arst_m_tlast",  64'(m_if.TLAST),  64'd0);
    chk("arst_m_tdest",  64'(m_if.TDEST),  64'd0);
    chk("arst_m_tid",    64'(m_if.TID),    64'd0);
    chk("arst_s_tready", 64'(s_if.TREADY), 64'd0);
    chk("arst_drop_cnt", 64'(drop_cnt),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
